prepare_eng_log_ring_ctrl: RTL

Control block for the prepare engine's log. It admits one log entry per request into a circular data memory and a circular header memory. Unlike the previous controller, it tracks real occupancy in beats and header slots, generates wrapping write addresses, and reserves space for the whole entry up front. It accepts frees of the oldest entries from commit/truncate logic and drains (drops) entries that do not fit.

---
 rtl/prepare_eng_log_ring_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/prepare_eng_log_ring_ctrl.sv
// Prepare-engine log ring controller.
// Admits one log entry per start into circular data and header memories,
// reserving the entry's full beat count and one header slot up front.
// Entries that do not fit are drained (beats accepted and discarded).
// Frees of the oldest entries return beats and slots, clamped at depth.
module prepare_eng_log_ring_ctrl #(
  parameter int LOG_AW = 10,
  parameter int HDR_AW = 6,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req_ingest,
  input  logic [LEN_W-1:0]  start_req_beats,
  output logic              log_write_done,
  output logic              log_write_dropped,
  output logic              log_len_err,
  input  logic              realign_log_ctrl_rd_val,
  input  logic              realign_log_ctrl_rd_last,
  output logic              log_ctrl_realign_rd_rdy,
  output logic              prep_log_hdr_mem_wr_val,
  input  logic              log_hdr_mem_prep_wr_rdy,
  output logic [HDR_AW-1:0] prep_log_hdr_mem_wr_addr,
  output logic [LOG_AW-1:0] prep_log_hdr_start_addr,
  output logic              prep_log_data_mem_wr_val,
  input  logic              log_data_mem_prep_wr_rdy,
  output logic [LOG_AW-1:0] prep_log_data_mem_wr_addr,
  input  logic              log_free_val,
  input  logic [LEN_W-1:0]  log_free_beats,
  output logic [LOG_AW:0]   log_data_free_cnt,
  output logic [HDR_AW:0]   log_hdr_free_cnt
);

  // Common compare width for beat counts and the data free count.
  localparam int CW = (LEN_W > LOG_AW + 1) ? LEN_W : LOG_AW + 1;
  // Header count arithmetic width (one guard bit above the count).
  localparam int HW = HDR_AW + 2;

  // Data depth D and header depth H, used as clamp limits.
  localparam logic [CW:0] DEPTH_D = {{(CW - LOG_AW){1'b0}}, 1'b1, {LOG_AW{1'b0}}};
  localparam logic [HW-1:0] DEPTH_H = {1'b0, 1'b1, {HDR_AW{1'b0}}};

  typedef enum logic [1:0] {
    D_READY   = 2'd0,
    D_WRITING = 2'd1,
    D_DRAIN   = 2'd2
  } data_state_t;

  typedef enum logic {
    H_WAITING = 1'b0,
    H_WR_HDR  = 1'b1
  } hdr_state_t;

  data_state_t r_data_state;
  data_state_t w_data_state_next;
  hdr_state_t  r_hdr_state;
  hdr_state_t  w_hdr_state_next;

  logic [LOG_AW-1:0] r_data_wr_ptr;
  logic [HDR_AW-1:0] r_hdr_wr_ptr;
  logic [LOG_AW:0]   r_data_free;
  logic [HDR_AW:0]   r_hdr_free;

  // Context of the entry in flight.
  logic [LEN_W-1:0]  r_beats;
  logic [LOG_AW-1:0] r_start;
  logic [HDR_AW-1:0] r_slot;
  logic [LEN_W-1:0]  r_n;
  logic              r_excess;
  logic              r_len_err;

  logic              w_done;
  logic              w_admit;
  logic              w_fit;
  logic              w_admit_fit;
  logic              w_admit_drop;
  logic [LEN_W-1:0]  w_req_beats;
  logic              w_in_range;
  logic              w_rd_rdy;
  logic              w_wr_val;
  logic              w_hdr_val;
  logic              w_beat_acc;
  logic [LEN_W-1:0]  w_n_final;
  logic              w_excess_final;
  logic [LOG_AW-1:0] w_wr_addr;
  logic [LOG_AW-1:0] w_entry_end;
  logic [CW:0]       w_data_sum;
  logic [LOG_AW:0]   w_data_free_next;
  logic [HW-1:0]     w_hdr_sum;
  logic [HDR_AW:0]   w_hdr_free_next;

  assign w_done      = (r_data_state == D_READY) && (r_hdr_state == H_WAITING);
  // Reset is folded in so the combinational drop pulse stays low during reset.
  assign w_admit     = w_done && start_req_ingest && !rst;
  // A zero-length request still occupies one beat.
  assign w_req_beats = (start_req_beats == '0) ? LEN_W'(1) : start_req_beats;
  // Fit decision uses only the registered counts; a same-cycle free cannot help.
  assign w_fit        = (CW'(w_req_beats) <= CW'(r_data_free)) && (r_hdr_free != '0);
  assign w_admit_fit  = w_admit && w_fit;
  assign w_admit_drop = w_admit && !w_fit;

  // Beats beyond the reserved count are swallowed without writing.
  assign w_in_range     = (r_n < r_beats);
  assign w_wr_addr      = r_start + r_n[LOG_AW-1:0];
  assign w_entry_end    = r_start + r_beats[LOG_AW-1:0];
  assign w_beat_acc     = (r_data_state == D_WRITING) && realign_log_ctrl_rd_val && w_rd_rdy;
  assign w_n_final      = r_n + LEN_W'(w_in_range);
  assign w_excess_final = r_excess || !w_in_range;

  // Net occupancy update: reserve on admit, release on free, clamp at depth.
  assign w_data_sum = {1'b0, CW'(r_data_free)}
                    - (w_admit_fit  ? {1'b0, CW'(w_req_beats)}    : '0)
                    + (log_free_val ? {1'b0, CW'(log_free_beats)} : '0);
  assign w_data_free_next = (w_data_sum > DEPTH_D) ? DEPTH_D[LOG_AW:0] : w_data_sum[LOG_AW:0];

  assign w_hdr_sum = {1'b0, r_hdr_free} - HW'(w_admit_fit) + HW'(log_free_val);
  assign w_hdr_free_next = (w_hdr_sum > DEPTH_H) ? DEPTH_H[HDR_AW:0] : w_hdr_sum[HDR_AW:0];

  // Data FSM next state and beat handshake steering.
  always_comb begin
    w_data_state_next = r_data_state;
    w_rd_rdy          = 1'b0;
    w_wr_val          = 1'b0;
    case (r_data_state)
      D_READY: begin
        if (w_admit_fit) begin
          w_data_state_next = D_WRITING;
        end else if (w_admit_drop) begin
          w_data_state_next = D_DRAIN;
        end
      end
      D_WRITING: begin
        w_rd_rdy = w_in_range ? log_data_mem_prep_wr_rdy : 1'b1;
        w_wr_val = w_in_range && realign_log_ctrl_rd_val;
        if (realign_log_ctrl_rd_val && w_rd_rdy && realign_log_ctrl_rd_last) begin
          w_data_state_next = D_READY;
        end
      end
      D_DRAIN: begin
        w_rd_rdy = 1'b1;
        if (realign_log_ctrl_rd_val && realign_log_ctrl_rd_last) begin
          w_data_state_next = D_READY;
        end
      end
      default: begin
        w_data_state_next = D_READY;
      end
    endcase
  end

  // Header FSM next state and header write request.
  always_comb begin
    w_hdr_state_next = r_hdr_state;
    w_hdr_val        = 1'b0;
    case (r_hdr_state)
      H_WAITING: begin
        if (w_admit_fit) begin
          w_hdr_state_next = H_WR_HDR;
        end
      end
      H_WR_HDR: begin
        w_hdr_val = 1'b1;
        if (log_hdr_mem_prep_wr_rdy) begin
          w_hdr_state_next = H_WAITING;
        end
      end
      default: begin
        w_hdr_state_next = H_WAITING;
      end
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_state <= D_READY;
      r_hdr_state  <= H_WAITING;
    end else begin
      r_data_state <= w_data_state_next;
      r_hdr_state  <= w_hdr_state_next;
    end
  end

  // Entry context capture, beat counting and write-pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beats       <= '0;
      r_start       <= '0;
      r_slot        <= '0;
      r_n           <= '0;
      r_excess      <= 1'b0;
      r_data_wr_ptr <= '0;
      r_hdr_wr_ptr  <= '0;
    end else begin
      if (w_admit) begin
        r_beats  <= w_req_beats;
        r_start  <= r_data_wr_ptr;
        r_slot   <= r_hdr_wr_ptr;
        r_n      <= '0;
        r_excess <= 1'b0;
        if (w_fit) begin
          r_hdr_wr_ptr <= r_hdr_wr_ptr + 1'b1;
        end
      end else if (w_beat_acc) begin
        r_n      <= w_n_final;
        r_excess <= w_excess_final;
        // Pointer moves by the reserved length even for short streams.
        if (realign_log_ctrl_rd_last) begin
          r_data_wr_ptr <= w_entry_end;
        end
      end
    end
  end

  // Length-mismatch pulse, raised the cycle after the last accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_beat_acc && realign_log_ctrl_rd_last &&
                   ((w_n_final != r_beats) || w_excess_final);
    end
  end

  // Free-space counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_free <= DEPTH_D[LOG_AW:0];
      r_hdr_free  <= DEPTH_H[HDR_AW:0];
    end else begin
      r_data_free <= w_data_free_next;
      r_hdr_free  <= w_hdr_free_next;
    end
  end

  assign log_write_done            = w_done;
  assign log_write_dropped         = w_admit_drop;
  assign log_len_err               = r_len_err;
  assign log_ctrl_realign_rd_rdy   = w_rd_rdy;
  assign prep_log_hdr_mem_wr_val   = w_hdr_val;
  assign prep_log_hdr_mem_wr_addr  = r_slot;
  assign prep_log_hdr_start_addr   = r_start;
  assign prep_log_data_mem_wr_val  = w_wr_val;
  assign prep_log_data_mem_wr_addr = w_wr_addr;
  assign log_data_free_cnt         = r_data_free;
  assign log_hdr_free_cnt          = r_hdr_free;

endmodule
